button_pulse_conditioner: RTL and testbench
===========================================

Name: button_pulse_conditioner

Overview:
- Front-end conditioner for the two game push-buttons.
- Synchronises the raw pad inputs, debounces them, and emits exactly one single-cycle press pulse per debounced press on btn_higher / btn_lower.
- Sits between the board pins and the higher/lower game core, so the core sees clean, mutually exclusive, one-shot requests.

Parameters:
- DEBOUNCE_CYCLES, 500_000: consecutive cycles a synchronised level must differ from the debounced level before the debounced level flips; legal range 1..2^CNT_W-1.
- CNT_W, 20: width of each debounce counter.
- REPEAT_CYCLES, 10_000_000: auto-repeat period in cycles; used only with the optional feature.
- REP_W, 24: width of the repeat counter; used only with the optional feature.

Ports:
- clk, input, 1: system clock; all state is on its rising edge.
- reset_n, input, 1: asynchronous active-low reset; low forces every register to its reset value immediately.
- raw_higher, input, 1: asynchronous pad, active-high, bouncy.
- raw_lower, input, 1: asynchronous pad, active-high, bouncy.
- btn_higher, output, 1: one-cycle press pulse for "higher".
- btn_lower, output, 1: one-cycle press pulse for "lower".
- held_higher, output, 1: debounced level of the higher button.
- held_lower, output, 1: debounced level of the lower button.
- conflict, output, 1: registered high while both debounced levels are 1.

Behaviour:
- Reset (reset_n low):
  - All sync flops, debounced levels, counters, pulses and conflict go to 0, i.e. buttons are treated as released.
  - Reset asserted mid-debounce or mid-pulse aborts the operation. No pulse is produced on reset release, even if a pad is already high.
  - A pad high at reset release produces a pulse only after full sync plus debounce.
- Synchroniser, per channel: 2-FF chain s1<=raw, s2<=s1.
- Debounce, per channel, with level db and counter cnt:
  - If s2==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=s2, cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce back to db before the count completes restarts the count from 0.
- Rise event: the edge at which db flips 0->1. Fall event: the edge at which db flips 1->0. Fall events never pulse.
- Pulse rule: on a rise event of channel X, the btn_X register is set to 1 for exactly one cycle if the other channel's db is 0 and the other channel has no rise event at the same edge. Otherwise btn_X stays 0.
- Simultaneous rise on both channels: neither pulses and conflict goes to 1.
- btn_higher and btn_lower are never 1 in the same cycle.
- Latency: raw held stable high before edge E1 -> btn high after edge E(2+DEBOUNCE_CYCLES), low after E(3+DEBOUNCE_CYCLES).
- Releasing one button while the other is held produces no pulse; a new pulse requires a fresh rise event.
- held_* equals db; conflict<=db_higher&db_lower (next-state values).

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- With the macro defined:
  - A REP_W repeat counter runs while exactly one db is 1 and conflict is 0.
  - It clears on any rise or fall event or on conflict.
  - When it reaches REPEAT_CYCLES-1, that channel's btn pulses for one cycle and the counter wraps to 0.
  - The first repeat pulse comes REPEAT_CYCLES cycles after the initial press pulse; repeats continue while held.
- Without the macro: the repeat counter is not built and exactly one pulse is produced per press.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16):
- raw_higher 0->1 clean before edge 1, held -> btn_higher=1 only in the cycle after edge 6; held_higher=1 from edge 6; btn_lower never 1.
- raw_lower toggles 1,0,1 on alternating cycles for 10 cycles, then holds 1 -> no pulse during bounce; single btn_lower pulse 6 edges after the final stable 1.
- raw_higher and raw_lower rise before the same edge -> no pulses, conflict=1 after edge 6; releasing raw_lower -> conflict=0 after 6 more edges, still no btn_higher pulse.
- raw_higher held, pulse seen, then reset_n low for 2 cycles mid-hold with raw_higher still 1 -> all outputs 0 during reset; exactly one btn_higher pulse 6 edges after reset_n returns high.
- raw_lower held 50 cycles with BUTTON_AUTO_REPEAT_EN defined -> pulses at edge 6, then every 16 cycles: edges 22 and 38; without the macro -> only the edge-6 pulse.

Source files
------------

// File: rtl/button_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// button_pulse_conditioner
//
// Front-end for the two game push-buttons. Each raw pad is passed through a
// 2-FF synchroniser and a counter-based debouncer. A debounced press becomes
// a single-cycle pulse on btn_higher / btn_lower. The two pulses are mutually
// exclusive, so the game core never sees two requests at once.
//
// Optional build macro: BUTTON_AUTO_REPEAT_EN
//   When defined, a single held button re-pulses every REPEAT_CYCLES cycles.
//   When undefined, each press produces exactly one pulse.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset (buttons treated as released)
//   raw_higher   raw asynchronous pad, active high, bouncy
//   raw_lower    raw asynchronous pad, active high, bouncy
//   btn_higher   one-cycle press pulse for "higher"
//   btn_lower    one-cycle press pulse for "lower"
//   held_higher  debounced level of the higher button
//   held_lower   debounced level of the lower button
//   conflict     high while both debounced levels are 1
// -----------------------------------------------------------------------------
module button_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int REP_W           = 24
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_higher,
    input  logic raw_lower,
    output logic btn_higher,
    output logic btn_lower,
    output logic held_higher,
    output logic held_lower,
    output logic conflict
);

    // Reject configurations whose terminal counts do not fit their counters.
    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2**CNT_W) - 1 ||
            REPEAT_CYCLES < 1 || REPEAT_CYCLES > (2**REP_W) - 1) begin : g_bad_params
            $error("button_pulse_conditioner: counter parameters out of range");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Channel index 0 = higher, 1 = lower.
    logic [1:0] raw_vec;
    logic [1:0] db_vec;    // current debounced levels
    logic [1:0] db_next;   // debounced levels after this edge
    logic [1:0] rise;      // db flips 0->1 at this edge
    logic [1:0] fall;      // db flips 1->0 at this edge

    assign raw_vec = {raw_lower, raw_higher};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic             s1_reg;
            logic             s2_reg;
            logic             db_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic             done;

            // The synchronised level has disagreed with db for the full
            // debounce window; db takes the new level at this edge.
            assign done        = (s2_reg != db_reg) && (cnt_reg == CNT_LAST);
            assign db_vec[gi]  = db_reg;
            assign db_next[gi] = done ? s2_reg : db_reg;
            assign rise[gi]    = done &  s2_reg;
            assign fall[gi]    = done & ~s2_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_reg  <= 1'b0;
                    s2_reg  <= 1'b0;
                    db_reg  <= 1'b0;
                    cnt_reg <= '0;
                end else begin
                    s1_reg <= raw_vec[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg == db_reg) begin
                        // Agreement (or a bounce back) restarts the window.
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= s2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    // A rise pulses only if the other button is released and not rising at
    // the same edge; this is what keeps the two pulses mutually exclusive.
    logic [1:0] press;
    assign press[0] = rise[0] & ~db_vec[1] & ~rise[1];
    assign press[1] = rise[1] & ~db_vec[0] & ~rise[0];

    logic [1:0] btn_reg;
    logic [1:0] btn_next;
    logic       conflict_reg;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_reg;
    logic             one_held;
    logic             any_event;
    logic             rep_fire;

    assign one_held  = db_vec[0] ^ db_vec[1];
    assign any_event = (|rise) | (|fall);
    // Any debounce event takes priority over a repeat, so a repeat can never
    // coincide with a fresh press on the other channel.
    assign rep_fire  = one_held & ~conflict_reg & ~any_event & (rep_reg == REP_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_reg <= '0;
        end else if (any_event || conflict_reg || !one_held) begin
            rep_reg <= '0;
        end else if (rep_reg == REP_LAST) begin
            rep_reg <= '0;
        end else begin
            rep_reg <= rep_reg + REP_W'(1);
        end
    end

    // Only the single held channel has db=1, so masking with db_vec picks it.
    assign btn_next = press | ({2{rep_fire}} & db_vec);
`else
    assign btn_next = press;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_reg      <= 2'b00;
            conflict_reg <= 1'b0;
        end else begin
            btn_reg      <= btn_next;
            conflict_reg <= db_next[0] & db_next[1];
        end
    end

    assign btn_higher  = btn_reg[0];
    assign btn_lower   = btn_reg[1];
    assign held_higher = db_vec[0];
    assign held_lower  = db_vec[1];
    assign conflict    = conflict_reg;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// Testbench for button_pulse_conditioner (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=16).
// Stimulus pushes expected pulses (channel + edge number) into a scoreboard;
// a monitor pops one entry per observed pulse. Level outputs are checked at
// hand-computed edges. Edge N means the N-th rising clock edge; outputs are
// sampled on the falling edge following it.
// -----------------------------------------------------------------------------
module tb_button_pulse_conditioner;

    localparam int DEB = 4;
    localparam int REP = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic raw_higher = 1'b0;
    logic raw_lower = 1'b0;
    logic btn_higher, btn_lower, held_higher, held_lower, conflict;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W(20),
        .REPEAT_CYCLES(REP),
        .REP_W(24)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw_higher(raw_higher),
        .raw_lower(raw_lower),
        .btn_higher(btn_higher),
        .btn_lower(btn_lower),
        .held_higher(held_higher),
        .held_lower(held_lower),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit ch;       // 0 = higher, 1 = lower
        int edge_n;   // edge after which the pulse is high
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_cnt);
        end
    endtask

    task automatic expect_pulse(input bit ch, input int e);
        exp_t x;
        x.ch = ch;
        x.edge_n = e;
        sb.push_back(x);
        $display("expect pulse on %s after edge %0d", ch ? "btn_lower" : "btn_higher", e);
    endtask

    task automatic wait_to(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    // Monitor: every observed pulse must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && (btn_higher || btn_lower)) begin
            if (btn_higher && btn_lower) begin
                checks++;
                errors++;
                $display("FAIL exclusive: both pulses high at edge %0d, required at most one", edge_cnt);
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: %s high at edge %0d, required none",
                         btn_lower ? "btn_lower" : "btn_higher", edge_cnt);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("pulse %s at edge %0d", btn_lower ? "btn_lower" : "btn_higher", edge_cnt);
                check("pulse_channel", 32'(btn_lower), 32'(e.ch));
                check("pulse_edge", edge_cnt, e.edge_n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int c;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_btn_higher", 32'(btn_higher), 0);
        check("rst_btn_lower", 32'(btn_lower), 0);
        check("rst_held_higher", 32'(held_higher), 0);
        check("rst_held_lower", 32'(held_lower), 0);
        check("rst_conflict", 32'(conflict), 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // T1: clean higher press, pulse after edge base+6
        raw_higher = 1'b1;
        base = edge_cnt;
        expect_pulse(0, base + 6);
        wait_to(base + 5);
        check("t1_held_before", 32'(held_higher), 0);
        wait_to(base + 6);
        check("t1_held_after", 32'(held_higher), 1);
        wait_to(base + 12);
        raw_higher = 1'b0;
        wait_to(base + 24);
        check("t1_released", 32'(held_higher), 0);

        // T2: bouncing lower, then stable
        for (int i = 0; i < 10; i++) begin
            raw_lower = (i % 2 == 0);
            @(negedge clk);
        end
        check("t2_bounce_held", 32'(held_lower), 0);
        raw_lower = 1'b1;
        base = edge_cnt;
        expect_pulse(1, base + 6);
        wait_to(base + 6);
        check("t2_held_after", 32'(held_lower), 1);
        wait_to(base + 12);
        raw_lower = 1'b0;
        wait_to(base + 24);

        // T3: simultaneous rise -> conflict, no pulses
        raw_higher = 1'b1;
        raw_lower = 1'b1;
        base = edge_cnt;
        wait_to(base + 5);
        check("t3_conflict_before", 32'(conflict), 0);
        wait_to(base + 6);
        check("t3_conflict_after", 32'(conflict), 1);
        check("t3_held_higher", 32'(held_higher), 1);
        check("t3_held_lower", 32'(held_lower), 1);
        wait_to(base + 8);
        raw_lower = 1'b0;
        c = edge_cnt;
        wait_to(c + 5);
        check("t3_conflict_hold", 32'(conflict), 1);
        wait_to(c + 6);
        check("t3_conflict_clear", 32'(conflict), 0);
        check("t3_lower_released", 32'(held_lower), 0);
        wait_to(c + 8);
        raw_higher = 1'b0;
        wait_to(c + 20);

        // T4: reset mid-hold, pulse again after full sync + debounce
        raw_higher = 1'b1;
        base = edge_cnt;
        expect_pulse(0, base + 6);
        wait_to(base + 8);
        reset_n = 1'b0;
        @(negedge clk);
        check("t4_rst_held", 32'(held_higher), 0);
        check("t4_rst_btn", 32'(btn_higher), 0);
        check("t4_rst_conflict", 32'(conflict), 0);
        @(negedge clk);
        reset_n = 1'b1;
        c = edge_cnt;
        expect_pulse(0, c + 6);
        wait_to(c + 5);
        check("t4_held_before", 32'(held_higher), 0);
        wait_to(c + 6);
        check("t4_held_after", 32'(held_higher), 1);
        wait_to(c + 12);
        raw_higher = 1'b0;
        wait_to(c + 24);

        // T5: long hold on lower (repeats only with auto-repeat built in)
        raw_lower = 1'b1;
        base = edge_cnt;
        expect_pulse(1, base + 6);
`ifdef BUTTON_AUTO_REPEAT_EN
        expect_pulse(1, base + 22);
        expect_pulse(1, base + 38);
`endif
        // Release so db falls at base+50, before a third repeat could fire.
        wait_to(base + 44);
        raw_lower = 1'b0;
        wait_to(base + 60);
        check("t5_released", 32'(held_lower), 0);

        check("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
